// File: rtl/run_monitor.sv
// Run-control monitor: tracks CPU instruction sync and PC stack,
// counts clocks/instructions and latches the first end-of-program cause.
module run_monitor #(
  parameter int PC_WIDTH    = 12,
  parameter int STACK_DEPTH = 4,
  parameter int PHASES      = 8,
  parameter int ROM_LIMIT   = 4096,
  parameter int LOOP_LIMIT  = 4,
  parameter int MAX_CYCLES  = 0,
  parameter int CNT_WIDTH   = 32,
  localparam int SP_WIDTH =
    (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            sync,
  input  logic [STACK_DEPTH*PC_WIDTH-1:0] pc_stack,
  input  logic [SP_WIDTH-1:0]             sp,
  output logic                            running,
  output logic                            halted,
  output logic                            done,
  output logic [2:0]                      cause,
  output logic [PC_WIDTH-1:0]             last_pc,
  output logic [CNT_WIDTH-1:0]            instr_count,
  output logic [CNT_WIDTH-1:0]            cycle_count
);

  localparam int PW = $clog2(PHASES);

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_SYNC  = 3'd1;
  localparam logic [2:0] C_SP    = 3'd2;
  localparam logic [2:0] C_PC    = 3'd3;
  localparam logic [2:0] C_LOOP  = 3'd4;
  localparam logic [2:0] C_TIME  = 3'd5;

  localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LOOPL = CNT_WIDTH'(LOOP_LIMIT);
  localparam logic [CNT_WIDTH-1:0] MAXC  = CNT_WIDTH'(MAX_CYCLES);
  localparam logic [31:0] ROM_LIM = 32'(ROM_LIMIT);
  localparam logic [31:0] DEPTH   = 32'(STACK_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUNNING,
    HALTED
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]        phase_q, phase_d;
  logic [CNT_WIDTH-1:0] instr_q, instr_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] loop_q, loop_d;
  logic [PC_WIDTH-1:0]  last_q, last_d;
  logic [2:0]           cause_q, cause_d;
  logic                 done_q, done_d;

  logic [PC_WIDTH-1:0]  pc;
  logic                 sp_bad;
  logic                 pc_hi;
  logic                 acc;
  logic                 err;
  logic                 judge;
  logic [2:0]           hit;

  // An out-of-range sp selects no entry; pc reads as zero then.
  always_comb begin
    pc = '0;
    for (int k = 0; k < STACK_DEPTH; k++) begin
      if (sp == SP_WIDTH'(k)) begin
        pc = pc_stack[k*PC_WIDTH +: PC_WIDTH];
      end
    end
  end

  assign sp_bad = 32'(sp) >= DEPTH;
  assign pc_hi  = 32'(pc) >= ROM_LIM;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    instr_d = instr_q;
    cycle_d = cycle_q;
    loop_d  = loop_q;
    last_d  = last_q;
    cause_d = cause_q;
    done_d  = 1'b0;
    acc     = 1'b0;
    err     = 1'b0;
    judge   = 1'b0;
    hit     = C_NONE;

    unique case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = ARMED;
          phase_d = '0;
          instr_d = '0;
          cycle_d = '0;
          loop_d  = '0;
          last_d  = '0;
          cause_d = C_NONE;
        end
      end
      ARMED: begin
        if (sync) begin
          state_d = RUNNING;
          phase_d = PH_ONE;
          instr_d = ONE;
          cycle_d = ONE;
          loop_d  = '0;
          last_d  = pc;
          acc     = 1'b1;
          judge   = 1'b1;
        end
      end
      RUNNING: begin
        judge   = 1'b1;
        cycle_d = cycle_q + ONE;
        phase_d = (phase_q == PH_LAST) ? '0
                                       : phase_q + PH_ONE;
        err     = sync != (phase_q == '0);
        if (sync) begin
          acc     = 1'b1;
          instr_d = instr_q + ONE;
          last_d  = pc;
          loop_d  = (pc == last_q) ? loop_q + ONE : '0;
        end
      end
      default: ;
    endcase

    if (err) begin
      hit = C_SYNC;
    end else if (acc && sp_bad) begin
      hit = C_SP;
    end else if (acc && pc_hi) begin
      hit = C_PC;
    end else if (acc && LOOP_LIMIT != 0 && loop_d == LOOPL) begin
      hit = C_LOOP;
    end else if (MAX_CYCLES != 0 && cycle_d == MAXC) begin
      hit = C_TIME;
    end

    if (judge && hit != C_NONE) begin
      state_d = HALTED;
      cause_d = hit;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      instr_q <= '0;
      cycle_q <= '0;
      loop_q  <= '0;
      last_q  <= '0;
      cause_q <= C_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      instr_q <= instr_d;
      cycle_q <= cycle_d;
      loop_q  <= loop_d;
      last_q  <= last_d;
      cause_q <= cause_d;
      done_q  <= done_d;
    end
  end

  assign running     = (state_q == ARMED) || (state_q == RUNNING);
  assign halted      = state_q == HALTED;
  assign done        = done_q;
  assign cause       = cause_q;
  assign last_pc     = last_q;
  assign instr_count = instr_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: two instances (no timeout / 20-clock timeout)
// checked every cycle against a sync-schedule model plus fixed literals.
module tb_run_monitor;

  localparam int PCW = 8;
  localparam int SD  = 5;
  localparam int SPW = 3;

  logic clock;
  logic reset;
  logic start;
  logic sync;
  logic [SD*PCW-1:0] pc_stack;
  logic [SPW-1:0] sp;

  logic a_running, a_halted, a_done;
  logic [2:0] a_cause;
  logic [PCW-1:0] a_last;
  logic [31:0] a_instr, a_cycle;

  logic b_running, b_halted, b_done;
  logic [2:0] b_cause;
  logic [PCW-1:0] b_last;
  logic [31:0] b_instr, b_cycle;

  int checks = 0;
  int errors = 0;
  bit fill_hi = 0;

  run_monitor #(
    .PC_WIDTH(PCW), .STACK_DEPTH(SD), .PHASES(8),
    .ROM_LIMIT(16), .LOOP_LIMIT(4), .MAX_CYCLES(0),
    .CNT_WIDTH(32)
  ) dut_a (
    .clock(clock), .reset(reset), .start(start),
    .sync(sync), .pc_stack(pc_stack), .sp(sp),
    .running(a_running), .halted(a_halted),
    .done(a_done), .cause(a_cause), .last_pc(a_last),
    .instr_count(a_instr), .cycle_count(a_cycle)
  );

  run_monitor #(
    .PC_WIDTH(PCW), .STACK_DEPTH(SD), .PHASES(8),
    .ROM_LIMIT(16), .LOOP_LIMIT(4), .MAX_CYCLES(20),
    .CNT_WIDTH(32)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start),
    .sync(sync), .pc_stack(pc_stack), .sp(sp),
    .running(b_running), .halted(b_halted),
    .done(b_done), .cause(b_cause), .last_pc(b_last),
    .instr_count(b_instr), .cycle_count(b_cycle)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // mode: 0 idle, 1 armed, 2 running, 3 halted
  typedef struct {
    int          mode;
    logic [2:0]  cause;
    logic [7:0]  last;
    logic [31:0] instr;
    logic [31:0] cycle;
    logic [31:0] loop;
    bit          done;
  } mdl_t;

  mdl_t ma = '{default: 0};
  mdl_t mb = '{default: 0};

  function automatic logic [7:0] pc_of(
    input logic [SD*PCW-1:0] st, input logic [SPW-1:0] s);
    if (s < SD) return st[s*PCW +: PCW];
    return 8'd0;
  endfunction

  // Syncs are due whenever the running clock count is a multiple of 8.
  function automatic mdl_t step(
    input mdl_t m, input int maxc, input bit r, input bit st,
    input bit sy, input logic [7:0] p, input bit spbad);
    mdl_t n;
    bit acc, err, judge;
    logic [2:0] c;
    n = m;
    n.done = 0;
    acc = 0; err = 0; judge = 0; c = 0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    case (m.mode)
      0, 3: if (st) begin
        n = '{default: 0};
        n.mode = 1;
      end
      1: if (sy) begin
        n.mode = 2; n.instr = 1; n.cycle = 1;
        n.last = p; n.loop = 0;
        acc = 1; judge = 1;
      end
      2: begin
        judge = 1;
        err = sy != ((m.cycle % 8) == 0);
        n.cycle = m.cycle + 1;
        if (sy) begin
          acc = 1;
          n.instr = m.instr + 1;
          n.loop = (p == m.last) ? m.loop + 1 : 0;
          n.last = p;
        end
      end
      default: ;
    endcase
    if (err) c = 1;
    else if (acc && spbad) c = 2;
    else if (acc && p >= 16) c = 3;
    else if (acc && n.loop == 4) c = 4;
    else if (maxc != 0 && n.cycle == maxc) c = 5;
    if (judge && c != 0) begin
      n.mode = 3; n.cause = c; n.done = 1;
    end
    return n;
  endfunction

  always @(posedge clock) begin
    ma = step(ma, 0, reset, start, sync,
              pc_of(pc_stack, sp), sp >= SD);
    mb = step(mb, 20, reset, start, sync,
              pc_of(pc_stack, sp), sp >= SD);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_dut(input string t, input mdl_t m,
    input logic run, input logic hlt, input logic dn,
    input logic [2:0] cs, input logic [7:0] lp,
    input logic [31:0] ic, input logic [31:0] cc);
    chk({t, ".running"}, 32'(run), 32'(m.mode == 1 || m.mode == 2));
    chk({t, ".halted"}, 32'(hlt), 32'(m.mode == 3));
    chk({t, ".done"}, 32'(dn), 32'(m.done));
    chk({t, ".cause"}, 32'(cs), 32'(m.cause));
    chk({t, ".last_pc"}, 32'(lp), 32'(m.last));
    chk({t, ".instr"}, ic, m.instr);
    chk({t, ".cycle"}, cc, m.cycle);
  endtask

  task automatic check_all();
    chk_dut("a", ma, a_running, a_halted, a_done,
            a_cause, a_last, a_instr, a_cycle);
    chk_dut("b", mb, b_running, b_halted, b_done,
            b_cause, b_last, b_instr, b_cycle);
  endtask

  task automatic cyc(input bit r, input bit st, input bit sy,
                     input logic [7:0] p, input int s);
    reset = r;
    start = st;
    sync  = sy;
    sp    = SPW'(s);
    for (int k = 0; k < SD; k++) begin
      pc_stack[k*PCW +: PCW] =
        fill_hi ? 8'd200 : 8'($urandom_range(0, 2));
    end
    if (s < SD) pc_stack[s*PCW +: PCW] = p;
    @(negedge clock);
    check_all();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic syn(input logic [7:0] p, input int s);
    cyc(0, 0, 1, p, s);
  endtask

  task automatic arm();
    cyc(0, 1, 0, 0, 0);
  endtask

  initial begin
    reset = 1; start = 0; sync = 0;
    sp = '0; pc_stack = '0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst.running", 32'(a_running), 0);
    chk("rst.cause", 32'(a_cause), 0);
    chk("rst.instr", a_instr, 0);

    // ROM limit: pc 0..16, one sync every 8 clocks
    arm();
    for (int i = 0; i <= 16; i++) begin
      syn(8'(i), 0);
      if (i < 16) gap(7);
    end
    chk("lim.halted", 32'(a_halted), 1);
    chk("lim.done", 32'(a_done), 1);
    chk("lim.cause", 32'(a_cause), 3);
    chk("lim.instr", a_instr, 17);
    chk("lim.cycle", a_cycle, 129);
    chk("lim.last_pc", 32'(a_last), 16);
    gap(1);
    chk("lim.done_drop", 32'(a_done), 0);
    chk("lim.frozen", a_cycle, 129);

    // self-loop at pc 5
    arm();
    for (int i = 0; i < 5; i++) begin
      syn(8'd5, 1);
      if (i < 4) gap(7);
    end
    chk("loop.cause", 32'(a_cause), 4);
    chk("loop.instr", a_instr, 5);

    // missing third sync
    arm();
    syn(0, 0); gap(7); syn(1, 0); gap(8);
    chk("miss.cause", 32'(a_cause), 1);
    chk("miss.cycle", a_cycle, 17);

    // early sync at phase 3
    arm();
    syn(0, 0); gap(2); syn(1, 0);
    chk("early.cause", 32'(a_cause), 1);

    // invalid sp beats pc limit
    arm();
    syn(0, 0); gap(7);
    fill_hi = 1;
    syn(8'd200, 5);
    fill_hi = 0;
    chk("sp.cause", 32'(a_cause), 2);

    // timeout on the MAX_CYCLES=20 instance
    arm();
    syn(1, 0); gap(7); syn(2, 0); gap(7); syn(3, 0); gap(3);
    chk("tmo.cause", 32'(b_cause), 5);
    chk("tmo.cycle", b_cycle, 20);
    chk("tmo.instr", b_instr, 3);

    // reset mid-run, re-arm, start while running
    arm();
    syn(1, 0); gap(3);
    cyc(1, 0, 0, 0, 0);
    chk("abort.running", 32'(a_running), 0);
    chk("abort.done", 32'(a_done), 0);
    chk("abort.cycle", a_cycle, 0);
    arm();
    syn(7, 0);
    chk("rearm.instr", a_instr, 1);
    chk("rearm.cycle", a_cycle, 1);
    gap(2);
    cyc(0, 1, 0, 0, 0);
    chk("ign.running", 32'(a_running), 1);
    chk("ign.cycle", a_cycle, 4);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      bit r, st, sy;
      int s;
      logic [7:0] p;
      r  = ($urandom % 500) == 0;
      st = ($urandom % 16) == 0;
      sy = ((k % 8) == 0) ^ (($urandom % 50) == 0);
      s  = (($urandom % 30) == 0) ? int'($urandom_range(5, 7))
                                   : int'($urandom_range(0, 4));
      p  = (($urandom % 40) == 0) ? 8'd17
                                   : 8'($urandom_range(0, 2));
      cyc(r, st, sy, p, s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
